// File: rtl/mmu_result_drain.sv
// -----------------------------------------------------------------------------
// mmu_result_drain
//   Consumer end of the MMU accumulated-result tile FIFO. When enabled and the
//   FIFO is non-empty it pops one SIZExSIZE tile of signed 32-bit accumulators.
//   Each element is post-processed (optional ReLU, arithmetic right shift,
//   saturation to OUT_BITS) and the tile is streamed row-major over a
//   valid/ready interface toward the unified buffer writer.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   acc_out       FIFO head tile, acc_out[row][col], signed 32-bit
//   acc_out_rdy   FIFO non-empty
//   acc_out_pop   one-cycle pop strobe
//   enable        permits popping new tiles
//   cfg_relu      clamp negative accumulators to zero
//   cfg_shift     arithmetic right-shift amount (0..31)
//   m_data        streamed element, signed OUT_BITS
//   m_valid       m_data valid
//   m_ready       downstream accepts on m_valid && m_ready
//   m_last        final element of the tile (row SIZE-1, col SIZE-1)
//   busy          block is not idle
//   tiles_done    count of fully streamed tiles (wraps)
// -----------------------------------------------------------------------------
module mmu_result_drain #(
  parameter int SIZE     = 2,
  parameter int OUT_BITS = 8,
  parameter int CNT_BITS = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [SIZE-1:0][SIZE-1:0][31:0]  acc_out,
  input  logic                             acc_out_rdy,
  output logic                             acc_out_pop,
  input  logic                             enable,
  input  logic                             cfg_relu,
  input  logic [4:0]                       cfg_shift,
  output logic [OUT_BITS-1:0]              m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             m_last,
  output logic                             busy,
  output logic [CNT_BITS-1:0]              tiles_done
);

  localparam int IDX_W = $clog2(SIZE);
  localparam int ELEMS = SIZE * SIZE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    WAIT   = 2'd2,
    STREAM = 2'd3
  } state_t;

  state_t                      state_reg, state_next;
  logic [IDX_W-1:0]            row_reg, col_reg;
  logic [CNT_BITS-1:0]         tiles_done_reg;
  logic [ELEMS*OUT_BITS-1:0]   tile_reg;
  logic [ELEMS*OUT_BITS-1:0]   elem_next;
  logic                        last_beat;
  logic                        beat_accept;
  int                          elem_idx;

  // ReLU, floor shift and saturation of one accumulator. Saturation checks
  // that every bit above the output sign bit matches it; otherwise the value
  // is out of range and clamps toward its own sign.
  function automatic logic [OUT_BITS-1:0] elem_math(
    input logic [31:0] a,
    input logic        relu,
    input logic [4:0]  shift
  );
    logic signed [31:0]   x;
    logic signed [31:0]   y;
    logic [32-OUT_BITS:0] hi;
    x  = (relu && a[31]) ? 32'sd0 : $signed(a);
    y  = x >>> shift;
    hi = y[31:OUT_BITS-1];
    if ((&hi) || !(|hi)) begin
      elem_math = y[OUT_BITS-1:0];
    end else if (y[31]) begin
      elem_math = {1'b1, {(OUT_BITS-1){1'b0}}};
    end else begin
      elem_math = {1'b0, {(OUT_BITS-1){1'b1}}};
    end
  endfunction

  // Post-processing is applied while capturing, so the configuration in force
  // at capture time is baked into the stored tile and later cfg changes
  // cannot affect the tile being streamed.
  genvar gi;
  generate
    for (gi = 0; gi < ELEMS; gi++) begin : g_elem
      assign elem_next[gi*OUT_BITS +: OUT_BITS] =
        elem_math(acc_out[gi / SIZE][gi % SIZE], cfg_relu, cfg_shift);
    end
  endgenerate

  assign last_beat   = (row_reg == LAST_IDX) && (col_reg == LAST_IDX);
  assign beat_accept = (state_reg == STREAM) && m_ready;
  assign tiles_done  = tiles_done_reg;

  always_comb begin
    elem_idx = int'(row_reg) * SIZE + int'(col_reg);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable && acc_out_rdy) state_next = POP;
      POP:     state_next = WAIT;
      // The FIFO presents the popped tile one cycle after the strobe.
      WAIT:    state_next = STREAM;
      STREAM:  if (m_ready && last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; m_valid depends only on state, never on m_ready.
  always_comb begin
    acc_out_pop = 1'b0;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    m_data      = '0;
    busy        = (state_reg != IDLE);
    case (state_reg)
      POP: acc_out_pop = 1'b1;
      STREAM: begin
        m_valid = 1'b1;
        m_last  = last_beat;
        m_data  = tile_reg[elem_idx*OUT_BITS +: OUT_BITS];
      end
      default: ;
    endcase
  end

  // Captured tile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_reg <= '0;
    end else if (state_reg == WAIT) begin
      tile_reg <= elem_next;
    end
  end

  // Row/column walk and tile counter. The counters wrap back to zero on the
  // last beat, so each tile starts from element (0,0) without extra clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg        <= '0;
      col_reg        <= '0;
      tiles_done_reg <= '0;
    end else if (beat_accept) begin
      if (col_reg == LAST_IDX) begin
        col_reg <= '0;
        row_reg <= (row_reg == LAST_IDX) ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
      if (last_beat) begin
        tiles_done_reg <= tiles_done_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmu_result_drain.sv
// -----------------------------------------------------------------------------
// tb_mmu_result_drain
//   Self-checking bench for mmu_result_drain (SIZE=2, OUT_BITS=8). A small
//   FIFO model presents the popped tile on acc_out one cycle after the pop
//   strobe. Expected elements come from directed tables and from a reference
//   model that uses integer floor division and explicit clamping.
// -----------------------------------------------------------------------------
module tb_mmu_result_drain;

  localparam int SIZE = 2;
  localparam int OB   = 8;
  localparam int CB   = 16;

  typedef logic [SIZE-1:0][SIZE-1:0][31:0] tile_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  tile_t             acc_out = '0;
  logic              acc_out_rdy;
  logic              acc_out_pop;
  logic              enable = 1'b0;
  logic              cfg_relu = 1'b0;
  logic [4:0]        cfg_shift = '0;
  logic [OB-1:0]     m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              m_last;
  logic              busy;
  logic [CB-1:0]     tiles_done;

  always #5 clk = ~clk;

  mmu_result_drain #(.SIZE(SIZE), .OUT_BITS(OB), .CNT_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .acc_out(acc_out), .acc_out_rdy(acc_out_rdy),
    .acc_out_pop(acc_out_pop), .enable(enable), .cfg_relu(cfg_relu),
    .cfg_shift(cfg_shift), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .tiles_done(tiles_done)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int exp_tiles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: tile_mem/wr_ptr written by the stimulus tasks only,
  // rd_ptr/acc_out/pop bookkeeping written by the pop process only.
  tile_t tile_mem [64];
  int    wr_ptr = 0;
  int    rd_ptr = 0;
  int    pop_count = 0;
  int    pop_cyc [64];

  assign acc_out_rdy = (wr_ptr != rd_ptr);

  always @(negedge clk) begin
    if (acc_out_pop) begin
      pop_count++;
      if (rd_ptr < wr_ptr) begin
        acc_out = tile_mem[rd_ptr];
        pop_cyc[rd_ptr] = cyc;
        rd_ptr++;
      end
    end
  end

  // Collected beats
  logic [OB-1:0] got_d [$];
  logic          got_l [$];
  int            got_c [$];
  bit            ready_pat [$];
  int            stall_changes;
  int            valid_drops;

  function automatic tile_t mk(input int a, input int b, input int c, input int d);
    tile_t t;
    t[0][0] = a; t[0][1] = b; t[1][0] = c; t[1][1] = d;
    return t;
  endfunction

  function automatic int ref_elem(input int a, input bit relu, input int sh);
    longint x, d, y;
    x = (relu && a < 0) ? 0 : longint'(a);
    d = longint'(1) << sh;
    if (x >= 0) y = x / d;
    else        y = -((-x + d - 1) / d);
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return int'(y);
  endfunction

  task automatic push_tile(input tile_t t);
    tile_mem[wr_ptr] = t;
    wr_ptr++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int maxc, output bit tmo);
    int c = 0;
    tmo = 0;
    while (!m_valid) begin
      if (c >= maxc) begin tmo = 1; break; end
      tick(); c++;
    end
  endtask

  // Drives m_ready and records accepted beats plus stall-stability events.
  task automatic collect(input int n, input int maxc, input int rdy_pct,
                         input bit scramble, output bit tmo);
    bit v, l, r, pv, pr, pl;
    logic [OB-1:0] d, pd;
    int beats = 0;
    int cycles = 0;
    pv = 0; pr = 0; pl = 0; pd = '0;
    got_d.delete(); got_l.delete(); got_c.delete();
    stall_changes = 0; valid_drops = 0; tmo = 0;
    while (beats < n) begin
      if (cycles >= maxc) begin tmo = 1; break; end
      v = m_valid; d = m_data; l = m_last;
      if (pv && !pr) begin
        if (!v) valid_drops++;
        if (d !== pd || l !== pl) stall_changes++;
      end
      if (ready_pat.size() > 0) r = ready_pat.pop_front();
      else r = ($urandom_range(99) < rdy_pct);
      m_ready = r;
      if (v && r) begin
        got_d.push_back(d); got_l.push_back(l); got_c.push_back(cyc);
        beats++;
      end
      if (scramble && beats >= 1) begin
        cfg_relu  = $urandom_range(1);
        cfg_shift = 5'($urandom_range(31));
      end
      pv = v; pr = r; pd = d; pl = l;
      tick(); cycles++;
    end
    m_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
    n_cmp++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last got=%b want=0", m_last); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (acc_out_pop !== 1'b0) begin n_fail++; $display("FAIL reset_pop got=%b want=0", acc_out_pop); end
    n_cmp++; if (m_data !== 8'd0) begin n_fail++; $display("FAIL reset_m_data got=%0d want=0", m_data); end
    n_cmp++; if (tiles_done !== 16'd0) begin n_fail++; $display("FAIL reset_tiles_done got=%0d want=0", tiles_done); end
    @(negedge clk); rst_n = 1;
    tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b want=0", busy); end
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    int exp_v [4] = '{1, 2, 3, 4};
    int p0;
    bit tmo;
    cfg_relu = 0; cfg_shift = 0; enable = 1;
    p0 = pop_count;
    push_tile(mk(1, 2, 3, 4));
    collect(4, 40, 100, 0, tmo);
    exp_tiles++;
    n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got=%0d beats want=4", got_d.size()); end
    if (!tmo) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (got_d[i] !== 8'(exp_v[i])) begin n_fail++; $display("FAIL basic_data[%0d] got=%0d want=%0d", i, $signed(got_d[i]), exp_v[i]); end
        n_cmp++; if (got_l[i] !== (i == 3)) begin n_fail++; $display("FAIL basic_last[%0d] got=%b want=%b", i, got_l[i], i == 3); end
        n_cmp++; if (got_c[i] !== got_c[0] + i) begin n_fail++; $display("FAIL basic_cycle[%0d] got=%0d want=%0d", i, got_c[i], got_c[0] + i); end
      end
      n_cmp++; if (got_c[0] !== pop_cyc[p0] + 2) begin n_fail++; $display("FAIL basic_latency got=%0d want=%0d", got_c[0], pop_cyc[p0] + 2); end
    end
    repeat (3) tick();
    n_cmp++; if (pop_count - p0 !== 1) begin n_fail++; $display("FAIL basic_pop_cycles got=%0d want=1", pop_count - p0); end
    n_cmp++; if (tiles_done !== 16'(exp_tiles)) begin n_fail++; $display("FAIL basic_tiles_done got=%0d want=%0d", tiles_done, exp_tiles); end
    n_cmp++; if (m_data !== 8'd0 || m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_out got=%0d/%b want=0/0", m_data, m_valid); end
    $display("test_basic: tile streamed, tiles_done=%0d", tiles_done);
  endtask

  task automatic test_stall();
    bit tmo;
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    cfg_relu = 0; cfg_shift = 0; enable = 1;
    push_tile(mk(1, 2, 3, 4));
    wait_valid(20, tmo);
    n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL stall_wait_valid got=timeout want=valid"); end
    for (int i = 0; i < 7; i++) ready_pat.push_back(pat[i]);
    collect(4, 20, 100, 0, tmo);
    exp_tiles++;
    n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL stall_timeout got=%0d beats want=4", got_d.size()); end
    if (!tmo) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (got_d[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL stall_data[%0d] got=%0d want=%0d", i, $signed(got_d[i]), i + 1); end
      end
      n_cmp++; if (got_c[3] - got_c[0] !== 6) begin n_fail++; $display("FAIL stall_span got=%0d want=6", got_c[3] - got_c[0]); end
    end
    n_cmp++; if (stall_changes !== 0) begin n_fail++; $display("FAIL stall_stable got=%0d changes want=0", stall_changes); end
    n_cmp++; if (valid_drops !== 0) begin n_fail++; $display("FAIL stall_valid_drop got=%0d want=0", valid_drops); end
    ready_pat.delete();
    tick();
    n_cmp++; if (tiles_done !== 16'(exp_tiles)) begin n_fail++; $display("FAIL stall_tiles_done got=%0d want=%0d", tiles_done, exp_tiles); end
    $display("test_stall: tile streamed under backpressure");
  endtask

  task automatic test_element_math();
    // relu, shift, four inputs, four expected outputs
    int tbl [7][10] = '{
      '{0, 0,  300, -300,  5, -5,  127, -128, 5, -5},
      '{0, 2,  300, -300,  7, -7,  75, -75, 1, -2},
      '{0, 1,  -5, 5, -1, 0,  -3, 2, -1, 0},
      '{0, 31, 32'h7FFFFFFF, 32'h80000000, -1, 1,  0, -1, -1, 0},
      '{1, 0,  -1000, 1000, -1, 5,  0, 127, 0, 5},
      '{1, 3,  1000, -8, -1000, 1023,  125, 0, 0, 127},
      '{0, 4,  -1, 16, -17, 1000,  -1, 1, -2, 62}
    };
    bit tmo;
    enable = 1;
    for (int t = 0; t < 7; t++) begin
      cfg_relu = tbl[t][0][0]; cfg_shift = 5'(tbl[t][1]);
      push_tile(mk(tbl[t][2], tbl[t][3], tbl[t][4], tbl[t][5]));
      collect(4, 60, 60, 0, tmo);
      exp_tiles++;
      n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL math_timeout row=%0d got=%0d beats want=4", t, got_d.size()); end
      if (!tmo) begin
        for (int i = 0; i < 4; i++) begin
          n_cmp++; if (got_d[i] !== 8'(tbl[t][6+i])) begin n_fail++; $display("FAIL math[%0d][%0d] in=%0d got=%0d want=%0d", t, i, tbl[t][2+i], $signed(got_d[i]), tbl[t][6+i]); end
        end
      end
      $display("test_element_math: row %0d relu=%0d shift=%0d streamed", t, tbl[t][0], tbl[t][1]);
    end
    tick();
    n_cmp++; if (tiles_done !== 16'(exp_tiles)) begin n_fail++; $display("FAIL math_tiles_done got=%0d want=%0d", tiles_done, exp_tiles); end
  endtask

  task automatic test_random();
    bit tmo;
    int vals [4];
    int exp_v;
    bit relu;
    int sh;
    enable = 1;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(1) == 1) vals[i] = int'($urandom);
        else vals[i] = int'($urandom_range(2000)) - 1000;
      end
      relu = $urandom_range(1);
      sh = ($urandom_range(3) == 0) ? int'($urandom_range(31)) : int'($urandom_range(4));
      cfg_relu = relu; cfg_shift = 5'(sh);
      push_tile(mk(vals[0], vals[1], vals[2], vals[3]));
      // cfg is scrambled once streaming has begun; it must not matter.
      collect(4, 80, 50, 1, tmo);
      exp_tiles++;
      n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL random_timeout tile=%0d got=%0d beats want=4", t, got_d.size()); end
      if (!tmo) begin
        for (int i = 0; i < 4; i++) begin
          exp_v = ref_elem(vals[i], relu, sh);
          n_cmp++; if (got_d[i] !== 8'(exp_v)) begin n_fail++; $display("FAIL random[%0d][%0d] in=%0d relu=%0d sh=%0d got=%0d want=%0d", t, i, vals[i], relu, sh, $signed(got_d[i]), exp_v); end
          n_cmp++; if (got_l[i] !== (i == 3)) begin n_fail++; $display("FAIL random_last[%0d][%0d] got=%b want=%b", t, i, got_l[i], i == 3); end
        end
      end
      n_cmp++; if (stall_changes !== 0 || valid_drops !== 0) begin n_fail++; $display("FAIL random_stable tile=%0d got=%0d/%0d want=0/0", t, stall_changes, valid_drops); end
      $display("test_random: tile %0d relu=%0d shift=%0d streamed", t, relu, sh);
    end
    cfg_relu = 0; cfg_shift = 0;
    tick();
    n_cmp++; if (tiles_done !== 16'(exp_tiles)) begin n_fail++; $display("FAIL random_tiles_done got=%0d want=%0d", tiles_done, exp_tiles); end
  endtask

  task automatic test_back_to_back();
    bit tmo;
    int p0;
    int max_busy = 0;
    int pops_before;
    cfg_relu = 0; cfg_shift = 0; enable = 1;
    p0 = pop_count;
    push_tile(mk(10, 20, 30, 40));
    push_tile(mk(50, 60, 70, 80));
    collect(8, 60, 100, 0, tmo);
    exp_tiles += 2;
    n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout got=%0d beats want=8", got_d.size()); end
    if (!tmo) begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++; if (got_d[i] !== 8'(10 * (i + 1))) begin n_fail++; $display("FAIL b2b_data[%0d] got=%0d want=%0d", i, $signed(got_d[i]), 10 * (i + 1)); end
      end
      n_cmp++; if (pop_cyc[p0 + 1] !== got_c[3] + 2) begin n_fail++; $display("FAIL b2b_pop_gap got=%0d want=%0d", pop_cyc[p0 + 1], got_c[3] + 2); end
      n_cmp++; if (got_c[4] !== got_c[3] + 4) begin n_fail++; $display("FAIL b2b_first_beat got=%0d want=%0d", got_c[4], got_c[3] + 4); end
    end
    tick();
    n_cmp++; if (tiles_done !== 16'(exp_tiles)) begin n_fail++; $display("FAIL b2b_tiles_done got=%0d want=%0d", tiles_done, exp_tiles); end
    $display("test_back_to_back: two tiles streamed");

    enable = 0;
    pops_before = pop_count;
    push_tile(mk(-1, -2, -3, -4));
    for (int i = 0; i < 10; i++) begin
      if (busy) max_busy = 1;
      tick();
    end
    n_cmp++; if (max_busy !== 0) begin n_fail++; $display("FAIL disabled_busy got=1 want=0"); end
    n_cmp++; if (pop_count !== pops_before) begin n_fail++; $display("FAIL disabled_pop got=%0d want=%0d", pop_count - pops_before, 0); end
    enable = 1;
    collect(4, 40, 100, 0, tmo);
    exp_tiles++;
    n_cmp++; if (tmo !== 1'b0 || got_d[0] !== 8'hFF) begin n_fail++; $display("FAIL enable_resume got=%0d beats want=4 starting -1", got_d.size()); end
    $display("test_back_to_back: enable gating checked");
  endtask

  task automatic test_reset_mid_tile();
    bit tmo;
    int pops_before;
    int max_busy = 0;
    cfg_relu = 0; cfg_shift = 0; enable = 1;
    push_tile(mk(11, 22, 33, 44));
    wait_valid(20, tmo);
    n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wait got=timeout want=valid"); end
    m_ready = 1;
    tick();
    n_cmp++; if (m_data !== 8'd22 || m_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_beat2 got=%0d/%b want=22/1", m_data, m_valid); end
    rst_n = 0;
    #1;
    n_cmp++; if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 || acc_out_pop !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl got=v%b l%b b%b p%b want=0000", m_valid, m_last, busy, acc_out_pop); end
    n_cmp++; if (m_data !== 8'd0) begin n_fail++; $display("FAIL rst_mid_data got=%0d want=0", m_data); end
    n_cmp++; if (tiles_done !== 16'd0) begin n_fail++; $display("FAIL rst_mid_tiles got=%0d want=0", tiles_done); end
    m_ready = 0;
    exp_tiles = 0;
    @(negedge clk); rst_n = 1;
    pops_before = pop_count;
    for (int i = 0; i < 5; i++) begin
      if (busy) max_busy = 1;
      tick();
    end
    n_cmp++; if (pop_count !== pops_before || max_busy !== 0) begin n_fail++; $display("FAIL rst_no_repop got=%0d pops busy=%0d want=0 pops busy=0", pop_count - pops_before, max_busy); end
    push_tile(mk(55, 66, 77, 88));
    collect(4, 40, 100, 0, tmo);
    exp_tiles++;
    n_cmp++; if (pop_count - pops_before !== 1) begin n_fail++; $display("FAIL rst_fresh_pop got=%0d want=1", pop_count - pops_before); end
    n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL rst_fresh_timeout got=%0d beats want=4", got_d.size()); end
    if (!tmo) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (got_d[i] !== 8'(55 + 11 * i)) begin n_fail++; $display("FAIL rst_fresh_data[%0d] got=%0d want=%0d", i, $signed(got_d[i]), 55 + 11 * i); end
      end
    end
    tick();
    n_cmp++; if (tiles_done !== 16'(exp_tiles)) begin n_fail++; $display("FAIL rst_fresh_tiles got=%0d want=%0d", tiles_done, exp_tiles); end
    $display("test_reset_mid_tile: fresh tile streamed after reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_element_math();
    test_random();
    test_back_to_back();
    test_reset_mid_tile();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=time limit want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
